// File: rtl/arcade_input_cond.sv
// arcade_input_cond: captures mod/DIP bytes from ioctl and produces rate-limited coin pulses.
// ARCADE_DIP_LIVE_EN: DIP writes go straight to dip_bus (no shadow, no download-end commit).
module arcade_input_cond #(
   parameter int NUM_DIP = 8,
   parameter int NUM_MOD = 4,
   parameter int NUM_COIN = 2,
   parameter int COIN_HOLD = 600000,
   parameter int COIN_GAP = 1200000,
   parameter logic [NUM_DIP*8-1:0] DIP_DEFAULT = '1
) (
   input  logic                   clk_12,
   input  logic                   reset,
   input  logic                   ioctl_download,
   input  logic                   ioctl_wr,
   input  logic [7:0]             ioctl_index,
   input  logic [24:0]            ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   input  logic [NUM_COIN-1:0]    coin_in,
   output logic [NUM_DIP*8-1:0]   dip_bus,
   output logic [NUM_MOD-1:0]     mod_sel,
   output logic                   mod_valid,
   output logic [NUM_COIN-1:0]    coin_out,
   output logic                   cfg_busy
);
   localparam int CW = $clog2(COIN_HOLD > COIN_GAP ? COIN_HOLD : COIN_GAP) + 1;
   localparam logic [1:0] IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2, WAIT_REL = 2'd3;
   logic dip_wr;
   logic [7:0] mod;
   assign dip_wr = ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'(NUM_DIP);
`ifdef ARCADE_DIP_LIVE_EN
   always_ff @(posedge clk_12 or posedge reset)
      if (reset)
         dip_bus <= DIP_DEFAULT;
      else if (dip_wr)
         for (int k = 0; k < NUM_DIP; k++)
            if (ioctl_addr == 25'(k)) dip_bus[8*k +: 8] <= ioctl_dout;
   assign cfg_busy = 1'b0;
`else
   logic [NUM_DIP*8-1:0] shadow;
   logic dirty, download_d;
   // a write landing on the commit edge keeps dirty set and waits for the next download end
   always_ff @(posedge clk_12 or posedge reset)
      if (reset) begin
         shadow <= DIP_DEFAULT;
         dip_bus <= DIP_DEFAULT;
         dirty <= 1'b0;
         download_d <= 1'b0;
      end else begin
         download_d <= ioctl_download;
         if (download_d && !ioctl_download && dirty) begin
            dip_bus <= shadow;
            dirty <= 1'b0;
         end
         if (dip_wr) begin
            for (int k = 0; k < NUM_DIP; k++)
               if (ioctl_addr == 25'(k)) shadow[8*k +: 8] <= ioctl_dout;
            dirty <= 1'b1;
         end
      end
   assign cfg_busy = dirty;
`endif
   always_ff @(posedge clk_12 or posedge reset)
      if (reset) begin
         mod <= 8'd0;
         mod_sel <= NUM_MOD'(1);
         mod_valid <= 1'b1;
      end else begin
         if (ioctl_wr && ioctl_index == 8'd1) mod <= ioctl_dout;
         mod_valid <= mod < 8'(NUM_MOD);
         mod_sel <= mod < 8'(NUM_MOD) ? NUM_MOD'(1) << mod : '0;
      end
   for (genvar i = 0; i < NUM_COIN; i++) begin : g_coin
      logic [2:0] sync;
      logic [1:0] state;
      logic [CW-1:0] cnt;
      // sync[1] is the synchronised level, sync[2] its previous value for edge detect
      always_ff @(posedge clk_12 or posedge reset)
         if (reset) begin
            sync <= '0;
            state <= IDLE;
            cnt <= '0;
         end else begin
            sync <= {sync[1:0], coin_in[i]};
            if (state == IDLE && sync[1] && !sync[2]) begin
               state <= PULSE;
               cnt <= CW'(COIN_HOLD);
            end else if ((state == PULSE || state == GAP) && cnt != CW'(1))
               cnt <= cnt - CW'(1);
            else if (state == PULSE) begin
               state <= GAP;
               cnt <= CW'(COIN_GAP);
            end else if (state == GAP)
               state <= WAIT_REL;
            else if (state == WAIT_REL && !sync[1])
               state <= IDLE;
         end
      assign coin_out[i] = state == PULSE;
   end
endmodule

// File: tb/tb_arcade_input_cond.sv
// tb_arcade_input_cond: scoreboard bench; stimulus queues expected output changes, a negedge monitor checks them.
module tb_arcade_input_cond;
   localparam logic [63:0] DEF = '1;
   typedef struct packed { int start; int len; } coin_t;
   logic clk_12 = 0, reset = 1, ioctl_download = 0, ioctl_wr = 0;
   logic [7:0] ioctl_index = 0, ioctl_dout = 0;
   logic [24:0] ioctl_addr = 0;
   logic [1:0] coin_in = 0;
   logic [63:0] dip_bus;
   logic [3:0] mod_sel;
   logic mod_valid, cfg_busy;
   logic [1:0] coin_out;
   int total = 0, bad = 0, cyc = 0;
   bit mon_on = 0;
   logic [63:0] dip_q[$];
   logic busy_q[$];
   logic [4:0] mod_q[$];
   coin_t c0_q[$], c1_q[$];
   logic [63:0] last_dip;
   logic last_busy;
   logic [4:0] last_mod;
   logic [1:0] last_coin;
   int cstart[2];

   arcade_input_cond #(.COIN_HOLD(4), .COIN_GAP(6)) dut (
      .clk_12(clk_12), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .coin_in(coin_in), .dip_bus(dip_bus), .mod_sel(mod_sel), .mod_valid(mod_valid),
      .coin_out(coin_out), .cfg_busy(cfg_busy));

   always #5 clk_12 = ~clk_12;
   always @(posedge clk_12) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      total++;
      bad++;
      $display("FAIL %s: unexpected change to %0h", name, act);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_12);
      #1;
   endtask

   task automatic wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
      ioctl_wr = 1;
      ioctl_index = idx;
      ioctl_addr = a;
      ioctl_dout = d;
      tick(1);
      ioctl_wr = 0;
   endtask

   always @(negedge clk_12) begin
      if (mon_on) begin
         if (dip_bus !== last_dip) begin
            if (dip_q.size() == 0) unexpected("dip_bus", dip_bus);
            else chk("dip_bus", dip_bus, dip_q.pop_front());
         end
         if (cfg_busy !== last_busy) begin
            if (busy_q.size() == 0) unexpected("cfg_busy", 64'(cfg_busy));
            else chk("cfg_busy", 64'(cfg_busy), 64'(busy_q.pop_front()));
         end
         if ({mod_valid, mod_sel} !== last_mod) begin
            if (mod_q.size() == 0) unexpected("mod", 64'({mod_valid, mod_sel}));
            else chk("mod", 64'({mod_valid, mod_sel}), 64'(mod_q.pop_front()));
         end
         for (int c = 0; c < 2; c++) begin
            coin_t e;
            if (coin_out[c] && !last_coin[c]) cstart[c] = cyc;
            if (!coin_out[c] && last_coin[c]) begin
               if ((c == 0 ? c0_q.size() : c1_q.size()) == 0) unexpected("coin_pulse", 64'(c));
               else begin
                  if (c == 0) e = c0_q.pop_front();
                  else e = c1_q.pop_front();
                  chk("coin_start", 64'(cstart[c]), 64'(e.start));
                  chk("coin_len", 64'(cyc - cstart[c]), 64'(e.len));
               end
            end
         end
      end
      last_dip = dip_bus;
      last_busy = cfg_busy;
      last_mod = {mod_valid, mod_sel};
      last_coin = coin_out;
   end

   initial begin
      int r;
      tick(2);
      chk("rst_dip", dip_bus, DEF);
      chk("rst_mod_sel", 64'(mod_sel), 64'h1);
      chk("rst_mod_valid", 64'(mod_valid), 64'h1);
      chk("rst_coin", 64'(coin_out), 64'h0);
      chk("rst_busy", 64'(cfg_busy), 64'h0);
      reset = 0;
      mon_on = 1;
      tick(1);
      // full bank plus one out-of-range byte
      ioctl_download = 1;
      busy_q.push_back(1'b1);
      for (int k = 0; k < 8; k++) wr(8'd254, 25'(k), 8'(8'h11 * (k + 1)));
      wr(8'd254, 25'd8, 8'hFF);
      tick(2);
      chk("dl_busy", 64'(cfg_busy), 64'h1);
      chk("dl_dip_hold", dip_bus, DEF);
      dip_q.push_back(64'h8877665544332211);
      busy_q.push_back(1'b0);
      ioctl_download = 0;
      tick(3);
      chk("commit_dip", dip_bus, 64'h8877665544332211);
      // write on the commit edge is deferred to the next download end
      ioctl_download = 1;
      busy_q.push_back(1'b1);
      wr(8'd254, 25'd0, 8'hA5);
      dip_q.push_back(64'h88776655443322A5);
      ioctl_download = 0;
      wr(8'd254, 25'd1, 8'h5B);
      chk("commit_wr_busy", 64'(cfg_busy), 64'h1);
      tick(1);
      ioctl_download = 1;
      tick(1);
      dip_q.push_back(64'h8877665544335BA5);
      busy_q.push_back(1'b0);
      ioctl_download = 0;
      tick(3);
      // mod select
      mod_q.push_back(5'b1_0100);
      mod_q.push_back(5'b1_1000);
      wr(8'd1, 25'd0, 8'd2);
      wr(8'd1, 25'd0, 8'd3);
      tick(2);
      chk("mod_sel3", 64'({mod_valid, mod_sel}), 64'h18);
      mod_q.push_back(5'b0_0000);
      wr(8'd1, 25'd0, 8'd7);
      tick(2);
      chk("mod_sel7", 64'({mod_valid, mod_sel}), 64'h0);
      // held button: one pulse; second press after gap: another
      coin_in[0] = 1;
      c0_q.push_back('{cyc + 3, 4});
      tick(40);
      coin_in[0] = 0;
      tick(5);
      coin_in[0] = 1;
      c0_q.push_back('{cyc + 3, 4});
      tick(3);
      coin_in[0] = 0;
      tick(15);
      // bounce during pulse and gap
      coin_in[1] = 1;
      c1_q.push_back('{cyc + 3, 4});
      tick(5);
      for (int k = 0; k < 6; k++) begin
         coin_in[1] = k[0];
         tick(1);
      end
      tick(15);
      coin_in[1] = 0;
      tick(10);
      // simultaneous channels
      coin_in = 2'b11;
      c0_q.push_back('{cyc + 3, 4});
      c1_q.push_back('{cyc + 3, 4});
      tick(3);
      coin_in = 2'b00;
      tick(15);
      // reset mid-download and mid-pulse
      ioctl_download = 1;
      busy_q.push_back(1'b1);
      coin_in[0] = 1;
      r = cyc;
      c0_q.push_back('{r + 3, 1});
      wr(8'd254, 25'd0, 8'h01);
      wr(8'd254, 25'd1, 8'h02);
      wr(8'd254, 25'd2, 8'h03);
      tick(1);
      dip_q.push_back(DEF);
      busy_q.push_back(1'b0);
      mod_q.push_back(5'b1_0001);
      reset = 1;
      #1;
      chk("arst_coin", 64'(coin_out), 64'h0);
      chk("arst_dip", dip_bus, DEF);
      chk("arst_busy", 64'(cfg_busy), 64'h0);
      chk("arst_mod", 64'({mod_valid, mod_sel}), 64'h11);
      tick(2);
      reset = 0;
      c0_q.push_back('{cyc + 3, 4});
      tick(2);
      ioctl_download = 0;
      tick(3);
      coin_in[0] = 0;
      tick(15);
      chk("post_rst_dip", dip_bus, DEF);
      chk("post_rst_busy", 64'(cfg_busy), 64'h0);
      chk("dip_q_left", 64'(dip_q.size()), 64'h0);
      chk("busy_q_left", 64'(busy_q.size()), 64'h0);
      chk("mod_q_left", 64'(mod_q.size()), 64'h0);
      chk("c0_q_left", 64'(c0_q.size()), 64'h0);
      chk("c1_q_left", 64'(c1_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
